// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction-fetch stage: owns the fetch PC (PCF), talks to instruction
//   memory through a single-outstanding request port, keeps one fetched word
//   in a local buffer, and drives the IF/ID pipeline register.
//
// Ports
//   clk            rising-edge clock
//   Reset          synchronous, active-low reset
//   StallF/StallD  hazard-unit stalls for the fetch and decode stages
//   FlushD         hazard-unit flush of the IF/ID register
//   BranchTakenE/BranchTargetE   execute-stage redirect (higher priority)
//   PCSrcW/ResultW               writeback-stage PC write
//   ImemReq/ImemAddr             request to instruction memory
//   ImemRdata/ImemValid          response from instruction memory
//   PCF            current fetch PC
//   InstrD/PCPlus4D/ValidD       IF/ID register contents
//   fetch_state    debug view of the fetch FSM state
//
// Memory handshake: ImemReq is a one-cycle request pulse carrying ImemAddr.
// The memory answers with a one-cycle ImemValid pulse (ImemRdata valid in
// that cycle) one or more cycles later. No new request is issued until the
// previous one has been answered, so ImemValid never needs a ready signal.
module fetch_unit (
    input  logic        clk,
    input  logic        Reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        BranchTakenE,
    input  logic [31:0] BranchTargetE,
    input  logic        PCSrcW,
    input  logic [31:0] ResultW,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic [31:0] ImemRdata,
    input  logic        ImemValid,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic [1:0]  fetch_state
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] buf_f;
    logic        buf_valid;

    logic        redirect;
    logic [31:0] target;
    logic        advance;
    logic [31:0] pc_plus4;

    // Execute-stage branch wins over a simultaneous writeback PC write.
    assign redirect = BranchTakenE | PCSrcW;
    assign target   = BranchTakenE ? BranchTargetE : ResultW;

    // The buffered word moves into decode only when neither stage is stalled
    // and the PC is not being redirected in the same cycle.
    assign advance  = buf_valid & ~StallF & ~StallD & ~redirect;
    assign pc_plus4 = PCF + 32'd4;

    // A request goes out only from FETCH with an empty buffer; a redirect in
    // the same cycle suppresses it because PCF is about to change.
    assign ImemReq     = Reset & (state == FETCH) & ~buf_valid & ~redirect;
    assign ImemAddr    = PCF;
    assign fetch_state = state;

    always_ff @(posedge clk) begin
        if (!Reset) begin
            state     <= FETCH;
            PCF       <= 32'd0;
            buf_f     <= 32'd0;
            buf_valid <= 1'b0;
            InstrD    <= 32'd0;
            PCPlus4D  <= 32'd0;
            ValidD    <= 1'b0;
        end else begin
            // Fetch FSM
            case (state)
                FETCH: begin
                    if (ImemReq) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        // Response for the old path: either discard it now or
                        // wait in DROP for it to arrive and discard it then.
                        state <= ImemValid ? FETCH : DROP;
                    end else if (ImemValid) begin
                        state <= FETCH;
                        buf_f <= ImemRdata;
                    end
                end
                DROP: begin
                    // Once the stale response is swallowed no request is in
                    // flight, so a redirect in this same cycle can go
                    // straight back to FETCH with the new PC.
                    if (ImemValid) begin
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase

            // PC and buffer occupancy
            if (redirect) begin
                PCF       <= target;
                buf_valid <= 1'b0;
            end else if (advance) begin
                PCF       <= pc_plus4;
                buf_valid <= 1'b0;
            end else if ((state == WAIT) && ImemValid) begin
                // Accepted even while StallF is high.
                buf_valid <= 1'b1;
            end

            // IF/ID register: hold on StallD, otherwise load or bubble.
            if (!StallD) begin
                if (advance && !FlushD) begin
                    InstrD   <= buf_f;
                    PCPlus4D <= pc_plus4;
                    ValidD   <= 1'b1;
                end else begin
                    InstrD   <= 32'd0;
                    PCPlus4D <= 32'd0;
                    ValidD   <= 1'b0;
                end
            end
        end
    end

endmodule
